// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU: FETCH/DECODE/MEM/EXEC over one shared req/ready memory port.
// Register ops 2 cycles, STA 3, LDA/ALU 4; each mem_ready-low cycle stalls with the request held stable.
module acc_cpu_core #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              execlk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                         OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_NOT = 4'h8,
                         OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB, OP_OUT = 4'hC,
                         OP_LDI = 4'hD, OP_HLT = 4'hF;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   mdr;
  logic [3:0]          ir_op;
  logic [ADDR_W-1:0]   ir_arg;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  assign sum = {1'b0, acc} + {1'b0, mdr};
  assign imm = {{(DATA_W-ADDR_W){1'b0}}, ir_arg};

  always_comb begin
    alu_res = acc;
    alu_c   = flag_c;
    case (ir_op)
      OP_LDA: alu_res = mdr;
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = acc - mdr;
        alu_c   = (mdr > acc);
      end
      OP_AND: alu_res = acc & mdr;
      OP_OR:  alu_res = acc | mdr;
      OP_XOR: alu_res = acc ^ mdr;
      OP_NOT: alu_res = ~acc;
      OP_LDI: alu_res = imm;
      default: ;
    endcase
  end

  always_ff @(posedge execlk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= ADDR_W'(RESET_PC);
      acc       <= '0;
      mdr       <= '0;
      ir_op     <= '0;
      ir_arg    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          // mem_req is only low here on the first cycle after reset
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir_op   <= mem_rdata[DATA_W-1 -: 4];
            ir_arg  <= mem_rdata[ADDR_W-1:0];
            pc      <= pc + ADDR_W'(1);
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          case (ir_op)
            OP_NOT, OP_LDI: begin
              acc    <= alu_res;
              flag_z <= (alu_res == '0);
            end
            OP_JMP: begin
              pc       <= ir_arg;
              mem_addr <= ir_arg;
            end
            OP_JZ: if (flag_z) begin
              pc       <= ir_arg;
              mem_addr <= ir_arg;
            end
            OP_JC: if (flag_c) begin
              pc       <= ir_arg;
              mem_addr <= ir_arg;
            end
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              state     <= S_MEM;
              mem_addr  <= ir_arg;
              mem_we    <= (ir_op == OP_STA);
              mem_wdata <= acc;
            end
            OP_HLT: begin
              state   <= S_HALT;
              mem_req <= 1'b0;
              halted  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_we) begin
              // store done: chain straight into the next fetch
              state    <= S_FETCH;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end else begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          acc      <= alu_res;
          flag_z   <= (alu_res == '0);
          flag_c   <= alu_c;
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        S_HALT: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          state   <= S_FETCH;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: stimulus queues expected memory transactions and OUT values,
// negedge monitors pop and compare whenever the cores present an accepted request or out strobe.
module tb_acc_cpu_core;

  logic        execlk = 1'b0;
  always #5 execlk = ~execlk;

  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, out_data;
  logic        out_valid, flag_z, flag_c, halted;
  logic [31:0] mem [0:4095];

  logic        rst2;
  logic        mem_req2, mem_we2, mem_ready2;
  logic [3:0]  mem_addr2;
  logic [15:0] mem_wdata2, mem_rdata2, out_data2;
  logic        out_valid2, flag_z2, flag_c2, halted2;
  logic [15:0] mem2 [0:15];

  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];

  acc_cpu_core #(.DATA_W(32), .ADDR_W(12), .RESET_PC(0)) dut (
    .execlk(execlk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .out_data(out_data),
    .out_valid(out_valid), .flag_z(flag_z), .flag_c(flag_c), .halted(halted));

  acc_cpu_core #(.DATA_W(16), .ADDR_W(4), .RESET_PC(15)) dut16 (
    .execlk(execlk), .rst(rst2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .flag_z(flag_z2), .flag_c(flag_c2), .halted(halted2));

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] out_q[$];
  logic [3:0]  exp2_q[$];
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          out_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic exp_rd(input int a);
    txn_t t;
    t.we = 1'b0; t.addr = 12'(a); t.wdata = '0;
    exp_q.push_back(t);
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = 12'(a); t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Monitor for the 32-bit core: every accepted transfer and every out strobe is scored
  always @(negedge execlk) begin
    if (rst && mem_req && mem_ready) begin
      if (mem_we) wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_txn_addr", 64'(mem_addr), 64'hFFFF_FFFF);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        check("txn_addr", 64'(mem_addr), 64'(e.addr));
        check("txn_we", 64'(mem_we), 64'(e.we));
        if (e.we) check("txn_wdata", 64'(mem_wdata), 64'(e.wdata));
      end
    end
    if (rst && out_valid) begin
      out_cnt++;
      if (out_q.size() == 0) check("unexpected_out", 64'(out_data), 64'hFFFF_FFFF);
      else check("out_data", 64'(out_data), 64'(out_q.pop_front()));
    end
  end

  always @(negedge execlk) begin
    if (rst2 && mem_req2 && mem_ready2) begin
      if (exp2_q.size() == 0) check("unexpected_txn16", 64'(mem_addr2), 64'hFFFF);
      else check("txn16_addr", 64'(mem_addr2), 64'(exp2_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge execlk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) step();
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 80) begin
      step();
      cyc++;
    end
    check("halted", 64'(halted), 64'(1));
  endtask

  task automatic drained(input string name);
    check({name, "_txn_q_empty"}, 64'(exp_q.size()), 64'(0));
    check({name, "_out_q_empty"}, 64'(out_q.size()), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w0;
    int o0;
    bit found;

    rst = 1'b0; rst2 = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b1;
    clear_mem();
    for (int i = 0; i < 16; i++) mem2[i] = '0;
    repeat (2) step();

    // reset state
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_flag_z", 64'(flag_z), 64'(0));
    check("rst_flag_c", 64'(flag_c), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));

    // 1: async reset in the middle of a stalled LDA operand read
    mem[0] = 32'h1000_000A; mem[1] = 32'hF000_0000; mem[10] = 32'h0000_0005;
    exp_rd(0);
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 12'd10) begin
        mem_ready = 1'b0;
        found = 1'b1;
      end
    end
    check("t1_reached_mem", 64'(found), 64'(1));
    repeat (2) step();
    check("t1_req_held", 64'(mem_req), 64'(1));
    check("t1_addr_held", 64'(mem_addr), 64'(10));
    #2;
    rst = 1'b0;
    #1;
    check("t1_async_req_low", 64'(mem_req), 64'(0));
    check("t1_fetch_consumed", 64'(exp_q.size()), 64'(0));
    step();
    mem_ready = 1'b1;
    exp_rd(0); exp_rd(10); exp_rd(1);
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = mem_req;
    end
    check("t1_first_fetch_addr", 64'(mem_addr), 64'(0));
    wait_halt(cyc);
    check("t1_z_after_lda5", 64'(flag_z), 64'(0));
    drained("t1");

    // 2: ADD with carry-out to zero, then HALT
    hold_reset();
    clear_mem();
    mem[0] = 32'hD000_0005; mem[1] = 32'h3000_000A; mem[2] = 32'hF000_0000; mem[10] = 32'hFFFF_FFFB;
    exp_rd(0); exp_rd(1); exp_rd(10); exp_rd(2);
    rst = 1'b1;
    wait_halt(cyc);
    check("t2_halt_cycle", 64'(cyc), 64'(9));
    check("t2_flag_z", 64'(flag_z), 64'(1));
    check("t2_flag_c", 64'(flag_c), 64'(1));
    repeat (8) step();
    check("t2_no_req_in_halt", 64'(mem_req), 64'(0));
    drained("t2");

    // 3: SUB with borrow, taken JC, OUT of the result
    hold_reset();
    clear_mem();
    mem[0] = 32'hD000_0003; mem[1] = 32'h4000_000A; mem[2] = 32'hB000_0007;
    mem[7] = 32'hC000_0000; mem[8] = 32'hF000_0000; mem[10] = 32'h0000_0004;
    exp_rd(0); exp_rd(1); exp_rd(10); exp_rd(2); exp_rd(7); exp_rd(8);
    out_q.push_back(32'hFFFF_FFFF);
    rst = 1'b1;
    wait_halt(cyc);
    check("t3_flag_c", 64'(flag_c), 64'(1));
    check("t3_flag_z", 64'(flag_z), 64'(0));
    check("t3_out_data", 64'(out_data), 64'hFFFF_FFFF);
    drained("t3");

    // 4: STA with mem_ready low for three cycles
    hold_reset();
    clear_mem();
    mem[0] = 32'hD000_0123; mem[1] = 32'h2000_0014; mem[2] = 32'hF000_0000;
    exp_rd(0); exp_rd(1); exp_wr(20, 32'h0000_0123); exp_rd(2);
    w0 = wr_cnt;
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_req && mem_we) begin
        mem_ready = 1'b0;
        found = 1'b1;
      end
    end
    check("t4_reached_sta", 64'(found), 64'(1));
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_req", 64'(mem_req), 64'(1));
      check("t4_hold_we", 64'(mem_we), 64'(1));
      check("t4_hold_addr", 64'(mem_addr), 64'(20));
      check("t4_hold_wdata", 64'(mem_wdata), 64'h123);
      step();
    end
    mem_ready = 1'b1;
    step();
    check("t4_next_fetch_req", 64'(mem_req), 64'(1));
    check("t4_next_fetch_we", 64'(mem_we), 64'(0));
    check("t4_next_fetch_addr", 64'(mem_addr), 64'(2));
    wait_halt(cyc);
    check("t4_write_count", 64'(wr_cnt - w0), 64'(1));
    drained("t4");

    // 5: OUT strobe width and hold
    hold_reset();
    clear_mem();
    mem[0] = 32'hD000_002A; mem[1] = 32'hC000_0000; mem[2] = 32'h0000_0000; mem[3] = 32'hF000_0000;
    exp_rd(0); exp_rd(1); exp_rd(2); exp_rd(3);
    out_q.push_back(32'h0000_002A);
    o0 = out_cnt;
    rst = 1'b1;
    wait_halt(cyc);
    repeat (4) step();
    check("t5_strobe_cycles", 64'(out_cnt - o0), 64'(1));
    check("t5_out_data_held", 64'(out_data), 64'h2A);
    check("t5_out_valid_low", 64'(out_valid), 64'(0));
    drained("t5");

    // 6: 16-bit/4-bit core, PC wrap 15->0 and 16-bit carry wrap
    mem2[15] = 16'hE000; mem2[0] = 16'hD005; mem2[1] = 16'h300A; mem2[2] = 16'hF000;
    mem2[10] = 16'hFFFB;
    exp2_q.push_back(4'd15); exp2_q.push_back(4'd0); exp2_q.push_back(4'd1);
    exp2_q.push_back(4'd10); exp2_q.push_back(4'd2);
    rst2 = 1'b1;
    cyc = 0;
    while (!halted2 && cyc < 80) begin
      step();
      cyc++;
    end
    check("t6_halted", 64'(halted2), 64'(1));
    check("t6_flag_z", 64'(flag_z2), 64'(1));
    check("t6_flag_c", 64'(flag_c2), 64'(1));
    check("t6_txn_q_empty", 64'(exp2_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
